// File: rtl/restoring_divider.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and dividend < divisor in one cycle.
module restoring_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // r_shift starts as the dividend; dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so it ends holding the full quotient.
  logic [7:0] r_shift;
  logic [3:0] r_divisor;
  logic [4:0] r_prem;
  logic [2:0] r_count;

  logic [5:0] w_trial;
  logic [4:0] w_sub;
  logic       w_qbit;
  logic [4:0] w_prem_next;
  logic [7:0] w_quot_next;
  logic       w_last;
  logic       w_div_zero;

  assign w_trial     = {r_prem, r_shift[7]};
  assign w_qbit      = (w_trial >= {2'b00, r_divisor});
  assign w_sub       = w_trial[4:0] - {1'b0, r_divisor};
  assign w_prem_next = w_qbit ? w_sub : w_trial[4:0];
  assign w_quot_next = {r_shift[6:0], w_qbit};
  assign w_last      = (r_count == 3'd7);
  assign w_div_zero  = (r_divisor == 4'd0);

`ifdef DIV_FAST_PATH_EN
  logic w_fast;
  assign w_fast = (divisor == 4'd0) || ({4'd0, divisor} > dividend);
`endif

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_FAST_PATH_EN
          w_next_state = w_fast ? S_DONE : S_RUN;
`else
          w_next_state = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // With a zero divisor every trial succeeds, so the partial remainder simply
  // collects the last dividend bits and its low nibble is dividend[3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'd0;
      r_divisor <= 4'd0;
      r_prem    <= 5'd0;
      r_count   <= 3'd0;
      quotient  <= 8'd0;
      remainder <= 4'd0;
      dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= dividend;
            r_divisor <= divisor;
            r_prem    <= 5'd0;
            r_count   <= 3'd0;
`ifdef DIV_FAST_PATH_EN
            if (w_fast) begin
              quotient  <= (divisor == 4'd0) ? 8'hFF : 8'h00;
              remainder <= dividend[3:0];
              dbz       <= (divisor == 4'd0);
            end
`endif
          end
        end
        S_RUN: begin
          r_shift <= w_quot_next;
          r_prem  <= w_prem_next;
          r_count <= r_count + 3'd1;
          if (w_last) begin
            quotient  <= w_div_zero ? 8'hFF : w_quot_next;
            remainder <= w_prem_next[3:0];
            dbz       <= w_div_zero;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: per-cycle model comparison plus
// directed literal cases; honours DIV_FAST_PATH_EN for expected latencies.
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  // model state, describing what should be visible after the latest edge
  bit mActive = 0;
  int mDoneIn = 0;
  int mQ = 0, mR = 0, mDbz = 0;
  int pQ = 0, pR = 0, pDbz = 0;

  restoring_divider dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void predict(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = 255;
      r = a % 16;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  function automatic bit isFast(input int a, input int b);
`ifdef DIV_FAST_PATH_EN
    return (b == 0) || (a < b);
`else
    return (a < 0) && (b < 0);
`endif
  endfunction

  function automatic int expLatency(input int a, input int b);
    return isFast(a, b) ? 1 : 9;
  endfunction

  // Compare process: checks the DUT against the model, then predicts the next edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mActive = 0;
        mDoneIn = 0;
        mQ = 0;
        mR = 0;
        mDbz = 0;
      end
      checkOutput("cyc.done", done, (mActive && mDoneIn == 0));
      checkOutput("cyc.busy", busy, (mActive && mDoneIn > 0));
      checkOutput("cyc.quotient", quotient, mQ);
      checkOutput("cyc.remainder", remainder, mR);
      checkOutput("cyc.dbz", dbz, mDbz);
      if (rst_n === 1'b1) begin
        if (!mActive) begin
          if (start === 1'b1) begin
            predict(int'(dividend), int'(divisor), pQ, pR, pDbz);
            mActive = 1;
            mDoneIn = isFast(int'(dividend), int'(divisor)) ? 0 : 8;
            if (mDoneIn == 0) begin
              mQ = pQ;
              mR = pR;
              mDbz = pDbz;
            end
          end
        end else if (mDoneIn == 0) begin
          mActive = 0;
        end else begin
          mDoneIn--;
          if (mDoneIn == 0) begin
            mQ = pQ;
            mR = pR;
            mDbz = pDbz;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [3:0] b);
    @(posedge clk);
    #1;
    start = s;
    dividend = a;
    divisor = b;
  endtask

  task automatic waitDone(output int dc, output bit ok);
    ok = 0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cycleNo;
        ok = 1;
        return;
      end
    end
    checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic runOne(input string name, input int a, input int b,
                        input int q, input int r, input int z, input int lat);
    int kCyc;
    int dCyc;
    bit ok;
    applyStimulus(1'b1, a[7:0], b[3:0]);
    @(posedge clk);
    #1;
    kCyc = cycleNo;
    start = 1'b0;
    waitDone(dCyc, ok);
    if (ok) begin
      checkOutput({name, ".latency"}, dCyc - kCyc + 1, lat);
      checkOutput({name, ".quotient"}, quotient, q);
      checkOutput({name, ".remainder"}, remainder, r);
      checkOutput({name, ".dbz"}, dbz, z);
    end
  endtask

  initial begin
    int kCyc, d1, d2, d3;
    bit ok;
    int a, b, q, r, z;

    rst_n = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 4'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.quotient", quotient, 0);
    checkOutput("reset.remainder", remainder, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.dbz", dbz, 0);
    rst_n = 1'b1;

    runOne("basic45_9", 45, 9, 5, 0, 0, 9);

    // back-to-back with start held high; next operands are set while RUN ignores them
    applyStimulus(1'b1, 8'd200, 4'd7);
    @(posedge clk);
    #1;
    kCyc = cycleNo;
    dividend = 8'd255;
    divisor = 4'd15;
    waitDone(d1, ok);
    checkOutput("b2b.lat1", d1 - kCyc + 1, 9);
    checkOutput("b2b.q200_7", quotient, 28);
    checkOutput("b2b.r200_7", remainder, 4);
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd255;
    divisor = 4'd1;
    waitDone(d2, ok);
    checkOutput("b2b.period1", d2 - d1, 10);
    checkOutput("b2b.q255_15", quotient, 17);
    checkOutput("b2b.r255_15", remainder, 0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(d3, ok);
    checkOutput("b2b.period2", d3 - d2, 10);
    checkOutput("b2b.q255_1", quotient, 255);
    checkOutput("b2b.r255_1", remainder, 0);

    runOne("dbz13_0", 13, 0, 255, 13, 1, expLatency(13, 0));
    runOne("after14_3", 14, 3, 4, 2, 0, 9);
    runOne("fast3_7", 3, 7, 0, 3, 0, expLatency(3, 7));

    // start pulse and operand change in cycle 4 of RUN must be ignored
    applyStimulus(1'b1, 8'd100, 4'd6);
    @(posedge clk);
    #1;
    kCyc = cycleNo;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 8'd77;
    divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(d1, ok);
    checkOutput("ignore.latency", d1 - kCyc + 1, 9);
    checkOutput("ignore.quotient", quotient, 16);
    checkOutput("ignore.remainder", remainder, 4);

    // reset in cycle 5 of RUN aborts at once
    applyStimulus(1'b1, 8'd100, 4'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort.quotient", quotient, 0);
    checkOutput("abort.remainder", remainder, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    checkOutput("abort.dbz", dbz, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    runOne("afterReset45_9", 45, 9, 5, 0, 0, 9);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      predict(a, b, q, r, z);
      runOne("rand", a, b, q, r, z, expLatency(a, b));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
